// File: rtl/relu_stream_ctrl.sv
// Streams NUM words from an input buffer through an external one-cycle ReLU unit and writes the
// results to an output buffer via a credit-protected skid FIFO.
module relu_stream_ctrl #(
  parameter int unsigned ROWS       = 64,
  parameter int unsigned COLS       = 64,
  parameter int unsigned AW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned DATA_W    = ROWS * COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       num_words,
  input  logic [AW-1:0]     rd_base,
  input  logic [AW-1:0]     wr_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              relu_en,
  output logic [DATA_W-1:0] relu_data,
  input  logic              relu_q_en,
  input  logic [DATA_W-1:0] relu_q,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [AW:0]        num_q, issued_q, written_q;
  logic [AW-1:0]      rd_base_q, wr_base_q;
  logic [1:0]         tag_q;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      count_q;
  logic               ovf_q;
  logic [CW:0]        occ;
  logic               push, pop, full, launch;

  // tag_q[0] marks a read whose data is on rd_data now, tag_q[1] one whose result is on relu_q
  assign occ    = {1'b0, count_q} + {{CW{1'b0}}, tag_q[0]} + {{CW{1'b0}}, tag_q[1]};
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign push   = relu_q_en & tag_q[1];
  assign pop    = wr_valid & wr_ready;
  assign launch = (state_q == StIdle) & start & ~abort;

  assign rd_en    = (state_q == StRun) && (issued_q < num_q) && (occ < (CW + 1)'(FIFO_DEPTH));
  assign rd_addr  = rd_base_q + issued_q[AW-1:0];
  assign relu_en  = tag_q[0];
  assign wr_valid = (count_q != '0);
  assign wr_addr  = wr_base_q + written_q[AW-1:0];

  always_comb begin
    relu_data = hold_q;
    wr_data   = '0;
    if (tag_q[0]) relu_data = rd_data;
    if (wr_valid) wr_data = mem[rptr_q];
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_words == '0) ? StDone : StRun;
      end
      StRun: begin
        if (issued_q == num_q) state_d = StDrain;
      end
      StDrain: begin
        // Leave on the final transfer so done follows the last write directly
        if (written_q == num_q || (pop && (written_q + (AW + 1)'(1) == num_q))) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      num_q     <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      issued_q  <= '0;
      written_q <= '0;
      tag_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (tag_q[0]) hold_q <= rd_data;
      if (abort) begin
        issued_q  <= '0;
        written_q <= '0;
        tag_q     <= '0;
      end else if (launch) begin
        num_q     <= num_words;
        rd_base_q <= rd_base;
        wr_base_q <= wr_base;
        issued_q  <= '0;
        written_q <= '0;
        tag_q     <= {tag_q[0], 1'b0};
      end else begin
        issued_q  <= issued_q + (AW + 1)'(rd_en);
        written_q <= written_q + (AW + 1)'(pop);
        tag_q     <= {tag_q[0], rd_en};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (relu_q_en && full) ovf_q <= 1'b1;
      if (abort) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !abort) mem[wptr_q] <= relu_q;
  end

  ovf_never: assert property (@(posedge clk) disable iff (rst) !ovf_q);

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Self-checking bench for relu_stream_ctrl: buffer and ReLU models plus an in-order scoreboard.
module tb_relu_stream_ctrl;

  localparam int unsigned ROWS       = 64;
  localparam int unsigned COLS       = 64;
  localparam int unsigned AW         = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DW         = ROWS * COLS;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } wr_item_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, wr_ready, relu_q_en;
  logic [AW:0]   num_words;
  logic [AW-1:0] rd_base, wr_base, rd_addr, wr_addr;
  logic          busy, done, rd_en, relu_en, wr_valid;
  logic [DW-1:0] rd_data, relu_data, relu_q, wr_data;

  int n_checks = 0;
  int n_fails  = 0;
  int mode     = 0;

  logic [AW-1:0] rd_exp [$];
  wr_item_t      wr_exp [$];

  relu_stream_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
    .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .relu_en(relu_en), .relu_data(relu_data),
    .relu_q_en(relu_q_en), .relu_q(relu_q), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] gen_word(input logic [AW-1:0] a, input int md);
    logic [DW-1:0] w;
    logic [63:0]   s;
    w = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (md == 1)
        s = (i % 2 == 0) ? (64'h8000_0000_0000_0001 + 64'(a)) : (64'h7FFF_FFFF_FFFF_FF00 - 64'(a));
      else
        s = ((64'(a) + 64'(i) + 64'd1) * 64'h9E37_79B9_7F4A_7C15) ^ (64'(i) << 40);
      w[i*COLS +: COLS] = s;
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] relu_fn(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    logic [63:0]   s;
    for (int i = 0; i < ROWS; i++) begin
      s = x[i*COLS +: COLS];
      r[i*COLS +: COLS] = s[63] ? 64'd0 : s;
    end
    return r;
  endfunction

  // Input buffer: data the cycle after the read strobe
  always @(posedge clk) if (rd_en) rd_data <= gen_word(rd_addr, mode);

  // ReLU unit: one-cycle latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      relu_q_en <= 1'b0;
      relu_q    <= '0;
    end else begin
      relu_q_en <= relu_en;
      relu_q    <= relu_fn(relu_data);
    end
  end

  // Scoreboard monitor
  wr_item_t      e;
  logic [AW-1:0] ea;
  int            out_n = 0;
  int            idx;
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        n_checks++;
        if (!wr_valid || wr_data !== hold_d || wr_addr !== hold_a) begin
          n_fails++;
          $display("FAIL wr_hold: valid=%b addr=%h expected valid=1 addr=%h data_same=%b",
                   wr_valid, wr_addr, hold_a, wr_data === hold_d);
        end
      end
      if (rd_en) begin
        n_checks++;
        if (rd_exp.size() == 0) begin
          n_fails++;
          $display("FAIL sb_rd_addr: unexpected read at %h, none expected", rd_addr);
        end else begin
          ea = rd_exp.pop_front();
          if (rd_addr !== ea) begin
            n_fails++;
            $display("FAIL sb_rd_addr: got %h expected %h", rd_addr, ea);
          end
        end
        out_n++;
        n_checks++;
        if (out_n > FIFO_DEPTH) begin
          n_fails++;
          $display("FAIL outstanding: got %0d expected <= %0d", out_n, FIFO_DEPTH);
        end
      end
      if (wr_valid && wr_ready) begin
        out_n--;
        n_checks++;
        if (wr_exp.size() == 0) begin
          n_fails++;
          $display("FAIL sb_write: unexpected write at %h, none expected", wr_addr);
        end else begin
          e = wr_exp.pop_front();
          if (wr_addr !== e.a) begin
            n_fails++;
            $display("FAIL sb_wr_addr: got %h expected %h", wr_addr, e.a);
          end else if (wr_data !== e.d) begin
            n_fails++;
            idx = 0;
            for (int i = ROWS - 1; i >= 0; i--)
              if (wr_data[i*COLS +: COLS] !== e.d[i*COLS +: COLS]) idx = i;
            $display("FAIL sb_wr_data: stream %0d got %h expected %h", idx,
                     wr_data[idx*COLS +: COLS], e.d[idx*COLS +: COLS]);
          end
        end
      end
      stall_q = wr_valid && !wr_ready;
      hold_d  = wr_data;
      hold_a  = wr_addr;
    end
    if (rst || abort) begin
      rd_exp.delete();
      wr_exp.delete();
      out_n   = 0;
      stall_q = 1'b0;
    end
  end

  task automatic launch(input int n, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                        input int md);
    wr_item_t it;
    mode = md;
    for (int k = 0; k < n; k++) begin
      rd_exp.push_back(rb + AW'(k));
      it.d = relu_fn(gen_word(rb + AW'(k), md));
      it.a = wb + AW'(k);
      wr_exp.push_back(it);
    end
    @(posedge clk); #1;
    num_words = (AW + 1)'(n);
    rd_base   = rb;
    wr_base   = wb;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
    num_words = '0; rd_base = '0; wr_base = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, rd_en, relu_en, wr_valid} !== 5'b0 || rd_addr !== '0 || wr_addr !== '0) begin
      n_fails++;
      $display("FAIL reset_ctrl: busy/done/rd_en/relu_en/wr_valid=%b rd_addr=%h wr_addr=%h expected 0",
               {busy, done, rd_en, relu_en, wr_valid}, rd_addr, wr_addr);
    end
    n_checks++;
    if (relu_data !== '0 || wr_data !== '0) begin
      n_fails++;
      $display("FAIL reset_data: relu_data ones=%0d wr_data ones=%0d expected 0",
               $countones(relu_data), $countones(wr_data));
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int first_rd = -1, last_rd = -1, rdn = 0, first_wv = -1, done_at = -1, done_n = 0;
    launch(8, 16'h0100, 16'h2000, 0);
    for (int t = 1; t <= 40; t++) begin
      if (rd_en) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t;
        rdn++;
      end
      if (wr_valid && first_wv < 0) first_wv = t;
      if (done) begin
        done_n++;
        done_at = t;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (first_rd !== 1 || last_rd !== 8 || rdn !== 8) begin
      n_fails++;
      $display("FAIL basic_reads: first=%0d last=%0d count=%0d expected 1 8 8", first_rd, last_rd, rdn);
    end
    n_checks++;
    if (first_wv !== first_rd + 3) begin
      n_fails++;
      $display("FAIL basic_latency: first wr_valid at %0d expected %0d", first_wv, first_rd + 3);
    end
    n_checks++;
    if (done_n !== 1 || done_at !== 12) begin
      n_fails++;
      $display("FAIL basic_done: count=%0d at=%0d expected 1 at 12", done_n, done_at);
    end
    n_checks++;
    if (wr_exp.size() !== 0) begin
      n_fails++;
      $display("FAIL basic_all_written: %0d left expected 0", wr_exp.size());
    end
  endtask

  task automatic test_sign();
    logic [DW-1:0] cap = '0;
    logic          got = 1'b0;
    logic [63:0]   exp1;
    exp1 = 64'h7FFF_FFFF_FFFF_FF00 - 64'h40;
    launch(4, 16'h0040, 16'h3000, 1);
    for (int t = 1; t <= 30; t++) begin
      if (wr_valid && wr_ready && !got) begin
        cap = wr_data;
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!got || cap[63:0] !== 64'd0) begin
      n_fails++;
      $display("FAIL sign_negative: got %h expected 0", cap[63:0]);
    end
    n_checks++;
    if (cap[127:64] !== exp1) begin
      n_fails++;
      $display("FAIL sign_positive: got %h expected %h", cap[127:64], exp1);
    end
  endtask

  task automatic test_backpressure();
    int rdn = 0, wrn = 0, done_n = 0, stall_rd = 0, occ = -1;
    launch(16, 16'h0200, 16'h4000, 0);
    for (int t = 1; t <= 80; t++) begin
      if (rd_en) begin
        rdn++;
        if (t >= 17 && t <= 26) stall_rd++;
      end
      if (wr_valid && wr_ready) wrn++;
      if (done) done_n++;
      if (t == 25) occ = rdn - wrn;
      @(posedge clk); #1;
      if (t == 6) wr_ready = 1'b0;
      if (t == 26) wr_ready = 1'b1;
    end
    n_checks++;
    if (occ !== FIFO_DEPTH || stall_rd !== 0) begin
      n_fails++;
      $display("FAIL bp_stall: buffered=%0d reads_in_stall=%0d expected %0d 0", occ, stall_rd, FIFO_DEPTH);
    end
    n_checks++;
    if (rdn !== 16 || wrn !== 16 || done_n !== 1 || wr_exp.size() !== 0) begin
      n_fails++;
      $display("FAIL bp_complete: reads=%0d writes=%0d done=%0d left=%0d expected 16 16 1 0",
               rdn, wrn, done_n, wr_exp.size());
    end
    n_checks++;
    if (dut.ovf_q !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_ovf: got %b expected 0", dut.ovf_q);
    end
  endtask

  task automatic test_zero();
    int done_at = -1, done_n = 0, act = 0;
    launch(0, 16'h0300, 16'h3300, 0);
    for (int t = 1; t <= 10; t++) begin
      if (done) begin
        done_n++;
        done_at = t;
      end
      if (rd_en || relu_en || wr_valid) act++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_n !== 1 || done_at !== 1) begin
      n_fails++;
      $display("FAIL zero_done: count=%0d at=%0d expected 1 at 1", done_n, done_at);
    end
    n_checks++;
    if (act !== 0) begin
      n_fails++;
      $display("FAIL zero_activity: %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_abort();
    int rdn = 0, done_n = 0, stale = 0, wrn = 0;
    logic ab_done = 1'b0;
    logic [AW-1:0] first_a = '0;
    launch(10, 16'h0500, 16'h5000, 0);
    for (int t = 1; t <= 25; t++) begin
      if (rd_en) rdn++;
      if (done) done_n++;
      if (t >= 7 && (wr_valid || busy || relu_en || rd_en)) stale++;
      @(posedge clk); #1;
      abort = (rdn == 5 && !ab_done);
      if (abort) ab_done = 1'b1;
    end
    n_checks++;
    if (done_n !== 0 || stale !== 0) begin
      n_fails++;
      $display("FAIL abort_quiet: done=%0d stale_cycles=%0d expected 0 0", done_n, stale);
    end
    launch(3, 16'h0600, 16'h6000, 0);
    done_n = 0;
    for (int t = 1; t <= 25; t++) begin
      if (wr_valid && wr_ready) begin
        if (wrn == 0) first_a = wr_addr;
        wrn++;
      end
      if (done) done_n++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (wrn !== 3 || first_a !== 16'h6000 || done_n !== 1) begin
      n_fails++;
      $display("FAIL abort_rerun: writes=%0d first_addr=%h done=%0d expected 3 6000 1",
               wrn, first_a, done_n);
    end
  endtask

  task automatic test_wrap_reset();
    logic [AW-1:0] seen [4];
    logic [AW-1:0] want [4];
    int rdn = 0;
    logic was_busy = 1'b0;
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
    for (int i = 0; i < 4; i++) seen[i] = '1;
    wr_ready = 1'b0;
    launch(4, 16'hFFFE, 16'h7000, 0);
    for (int t = 1; t <= 8; t++) begin
      if (rd_en && rdn < 4) begin
        seen[rdn] = rd_addr;
        rdn++;
      end
      if (t == 8) was_busy = busy;
      else begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (seen[i] !== want[i]) begin
        n_fails++;
        $display("FAIL wrap_rd_addr[%0d]: got %h expected %h", i, seen[i], want[i]);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (!was_busy || {busy, done, rd_en, relu_en, wr_valid} !== 5'b0 ||
        rd_addr !== '0 || wr_addr !== '0 || relu_data !== '0 || wr_data !== '0) begin
      n_fails++;
      $display("FAIL wrap_reset: busy_before=%b ctrl=%b rd_addr=%h wr_addr=%h data_ones=%0d expected 1 0 0 0 0",
               was_busy, {busy, done, rd_en, relu_en, wr_valid}, rd_addr, wr_addr,
               $countones(relu_data) + $countones(wr_data));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_idle: busy=%b wr_valid=%b expected 0 0", busy, wr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_zero();
    test_abort();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
